// File: rtl/seq_match_logger.sv
// Timestamps seq_seen pulses with a free-running position counter and
// queues them in a FWFT FIFO with saturating match count and sticky overflow.
// Ports: clk, reset (sync, active-high), seq_seen, rd_en -> rd_data,
//        rd_valid, fifo_full, level, overflow, match_count.
module seq_match_logger #(
  parameter int POS_WIDTH = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     seq_seen,
  input  logic                     rd_en,
  output logic [POS_WIDTH-1:0]     rd_data,
  output logic                     rd_valid,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     match_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_t;

  occ_t                 state;
  logic [POS_WIDTH-1:0] pos;
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [POS_WIDTH-1:0] mem [DEPTH];

  logic       pop;
  logic       wr;
  logic       drop;
  logic [AW:0] lvl_nxt;

  assign rd_valid  = (state != EMPTY);
  assign fifo_full = (state == FULL);
  assign rd_data   = mem[rptr];

  always_comb begin
    pop     = rd_en && rd_valid;
    // When full, a push only lands if the head leaves in the same cycle;
    // the tail slot then aliases the departing head slot.
    wr      = seq_seen && (!fifo_full || pop);
    drop    = seq_seen && fifo_full && !pop;
    lvl_nxt = level;
    if (wr && !pop)
      lvl_nxt = level + 1'b1;
    else if (pop && !wr)
      lvl_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      pos         <= '0;
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      match_count <= '0;
    end else begin
      pos   <= pos + 1'b1;
      level <= lvl_nxt;
      if (lvl_nxt == '0)
        state <= EMPTY;
      else if (lvl_nxt == FULL_LVL)
        state <= FULL;
      else
        state <= PARTIAL;
      if (wr)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      if (seq_seen && match_count != CNT_MAX)
        match_count <= match_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr)
      mem[wptr] <= pos;
  end

endmodule
